// File: rtl/bus_dpram_pkg.sv
// Shared definitions for the bus-attached dual-port RAM with doorbell/response mailbox.
package bus_dpram_pkg;

    localparam int unsigned BUS_W = 16;
    localparam int unsigned REG_IDX_W = 3;

    // Register indexes (byte offsets 0x0, 0x2, 0x4, 0x6 within the register window)
    localparam logic [REG_IDX_W-1:0] REG_STATUS  = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_MSG_LEN = 3'd1;
    localparam logic [REG_IDX_W-1:0] REG_RSP_LEN = 3'd2;
    localparam logic [REG_IDX_W-1:0] REG_INFO    = 3'd3;

    localparam int unsigned STAT_MSG_PEND = 0;
    localparam int unsigned STAT_RSP_FULL = 1;
    localparam int unsigned STAT_OVERRUN  = 2;
    localparam int unsigned STAT_TIMEOUT  = 3;

    typedef enum logic [0:0] {
        DB_IDLE = 1'b0,
        DB_PEND = 1'b1
    } db_state_e;

    // Packs the STATUS register view from its individual flags.
    function automatic logic [BUS_W-1:0] status_word(input logic pend,
                                                     input logic full,
                                                     input logic ovr,
                                                     input logic tmo);
        logic [BUS_W-1:0] w;
        w                = '0;
        w[STAT_MSG_PEND] = pend;
        w[STAT_RSP_FULL] = full;
        w[STAT_OVERRUN]  = ovr;
        w[STAT_TIMEOUT]  = tmo;
        return w;
    endfunction

endpackage

// File: rtl/bus_dpram_mailbox_ram.sv
// Single-clock true dual-port RAM; each port reads the pre-write contents of a word.
module Dual_Port_RAM_Single_Clock #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     i_Clk,
    input  logic [$clog2(DEPTH)-1:0] i_PortA_Addr,
    input  logic [WIDTH-1:0]         i_PortA_Data,
    input  logic                     i_PortA_WE,
    output logic [WIDTH-1:0]         o_PortA_Data,
    input  logic [$clog2(DEPTH)-1:0] i_PortB_Addr,
    input  logic [WIDTH-1:0]         i_PortB_Data,
    input  logic                     i_PortB_WE,
    output logic [WIDTH-1:0]         o_PortB_Data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Callers guarantee the two ports never write the same word in one cycle.
    always_ff @(posedge i_Clk) begin
        if (i_PortA_WE) begin
            mem_q[i_PortA_Addr] <= i_PortA_Data;
        end
        if (i_PortB_WE) begin
            mem_q[i_PortB_Addr] <= i_PortB_Data;
        end
        o_PortA_Data <= mem_q[i_PortA_Addr];
        o_PortB_Data <= mem_q[i_PortB_Addr];
    end

endmodule

// File: rtl/bus_dpram_mailbox.sv
// Bus-attached dual-port RAM with a doorbell/response mailbox and interrupt.
// Optional doorbell ack timeout: define BUS_DPRAM_MBOX_TIMEOUT_EN.
module bus_dpram_mailbox
    import bus_dpram_pkg::*;
#(
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned RD_PIPE        = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     i_Bus_Clk,
    input  logic                     i_Bus_Rst_L,
    input  logic                     i_Bus_CS,
    input  logic                     i_Bus_Wr_Rd_n,
    input  logic [15:0]              i_Bus_Addr8,
    input  logic [15:0]              i_Bus_Wr_Data,
    output logic [15:0]              o_Bus_Rd_Data,
    output logic                     o_Bus_Rd_DV,
    output logic                     o_Bus_Irq,
    input  logic [$clog2(DEPTH)-1:0] i_PortB_Addr16,
    input  logic [15:0]              i_PortB_Data,
    input  logic                     i_PortB_WE,
    output logic [15:0]              o_PortB_Data,
    output logic                     o_PortB_Collision,
    output logic                     o_PortB_Msg_Valid,
    output logic [15:0]              o_PortB_Msg_Len,
    input  logic                     i_PortB_Msg_Ack,
    input  logic                     i_PortB_Rsp_Valid,
    input  logic [15:0]              i_PortB_Rsp_Len,
    output logic                     o_PortB_Rsp_Ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = BUS_W;

    // Address decode
    logic                 reg_sel_c;
    logic [AW-1:0]        ram_addr_c;
    logic [REG_IDX_W-1:0] reg_idx_c;
    logic                 wr_c;
    logic                 rd_c;
    logic                 ram_we_a_c;
    logic                 ram_we_b_c;
    logic                 collide_c;
    logic                 msg_wr_c;
    logic                 stat_wr_c;
    logic                 rsp_rd_c;
    logic                 rsp_accept_c;
    logic                 unused_ok;

    assign reg_sel_c    = i_Bus_Addr8[AW+1];
    assign ram_addr_c   = i_Bus_Addr8[AW:1];
    assign reg_idx_c    = i_Bus_Addr8[3:1];
    assign wr_c         = i_Bus_CS & i_Bus_Wr_Rd_n;
    assign rd_c         = i_Bus_CS & ~i_Bus_Wr_Rd_n;
    assign ram_we_a_c   = wr_c & ~reg_sel_c;
    assign collide_c    = ram_we_a_c & i_PortB_WE & (ram_addr_c == i_PortB_Addr16);
    assign ram_we_b_c   = i_PortB_WE & ~collide_c;
    assign msg_wr_c     = wr_c & reg_sel_c & (reg_idx_c == REG_MSG_LEN);
    assign stat_wr_c    = wr_c & reg_sel_c & (reg_idx_c == REG_STATUS);
    assign rsp_rd_c     = rd_c & reg_sel_c & (reg_idx_c == REG_RSP_LEN);
    assign rsp_accept_c = i_PortB_Rsp_Valid & o_PortB_Rsp_Ready;

`ifdef BUS_DPRAM_MBOX_TIMEOUT_EN
    assign unused_ok = ^{i_Bus_Addr8[15:AW+2], i_Bus_Addr8[0]};
`else
    assign unused_ok = ^{i_Bus_Addr8[15:AW+2], i_Bus_Addr8[0], 32'(TIMEOUT_CYCLES)};
`endif

    logic [DW-1:0] ram_dout_a;

    Dual_Port_RAM_Single_Clock #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_Clk        (i_Bus_Clk),
        .i_PortA_Addr (ram_addr_c),
        .i_PortA_Data (i_Bus_Wr_Data),
        .i_PortA_WE   (ram_we_a_c),
        .o_PortA_Data (ram_dout_a),
        .i_PortB_Addr (i_PortB_Addr16),
        .i_PortB_Data (i_PortB_Data),
        .i_PortB_WE   (ram_we_b_c),
        .o_PortB_Data (o_PortB_Data)
    );

    // Mailbox and read-capture state
    db_state_e     state_q,       state_d;
    logic          msg_valid_q,   msg_valid_d;
    logic [DW-1:0] msg_len_q,     msg_len_d;
    logic [DW-1:0] msg_shadow_q,  msg_shadow_d;
    logic          overrun_q,     overrun_d;
    logic          timeout_q,     timeout_d;
    logic          rsp_full_q,    rsp_full_d;
    logic [DW-1:0] rsp_len_q,     rsp_len_d;
    logic          rsp_ready_q,   rsp_ready_d;
    logic          irq_q,         irq_d;
    logic          collision_q,   collision_d;
    logic          rd_vld_q,      rd_vld_d;
    logic          rd_is_reg_q,   rd_is_reg_d;
    logic [DW-1:0] rd_reg_data_q, rd_reg_data_d;
    logic          timeout_hit_c;
    logic [DW-1:0] reg_rdata_c;

`ifdef BUS_DPRAM_MBOX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Register read view, sampled in the access cycle
    always_comb begin
        reg_rdata_c = '0;
        case (reg_idx_c)
            REG_STATUS:  reg_rdata_c = status_word(state_q == DB_PEND, rsp_full_q,
                                                   overrun_q, timeout_q);
            REG_MSG_LEN: reg_rdata_c = msg_shadow_q;
            REG_RSP_LEN: reg_rdata_c = rsp_len_q;
            REG_INFO:    reg_rdata_c = DW'(DEPTH);
            default:     reg_rdata_c = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        msg_valid_d   = msg_valid_q;
        msg_len_d     = msg_len_q;
        msg_shadow_d  = msg_shadow_q;
        overrun_d     = overrun_q;
        timeout_d     = timeout_q;
        rsp_full_d    = rsp_full_q;
        rsp_len_d     = rsp_len_q;
        timeout_hit_c = 1'b0;
`ifdef BUS_DPRAM_MBOX_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif

        // Clears go first so a same-cycle hardware set is not lost
        if (stat_wr_c) begin
            if (i_Bus_Wr_Data[STAT_OVERRUN]) overrun_d = 1'b0;
            if (i_Bus_Wr_Data[STAT_TIMEOUT]) timeout_d = 1'b0;
        end
        if (msg_wr_c) begin
            msg_shadow_d = i_Bus_Wr_Data;
        end

        case (state_q)
            DB_IDLE: begin
`ifdef BUS_DPRAM_MBOX_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                if (msg_wr_c) begin
                    state_d     = DB_PEND;
                    msg_valid_d = 1'b1;
                    msg_len_d   = i_Bus_Wr_Data;
                end
            end
            DB_PEND: begin
                if (msg_wr_c) begin
                    overrun_d = 1'b1;
                end
                if (i_PortB_Msg_Ack) begin
                    state_d     = DB_IDLE;
                    msg_valid_d = 1'b0;
                end
`ifdef BUS_DPRAM_MBOX_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = DB_IDLE;
                    msg_valid_d   = 1'b0;
                    timeout_d     = 1'b1;
                    timeout_hit_c = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
        endcase

        // A RSP_LEN read frees the slot; an accept can only happen while it is empty
        if (rsp_rd_c) begin
            rsp_full_d = 1'b0;
        end
        if (rsp_accept_c) begin
            rsp_full_d = 1'b1;
            rsp_len_d  = i_PortB_Rsp_Len;
        end

        rsp_ready_d   = ~rsp_full_d;
        irq_d         = rsp_full_d | timeout_hit_c;
        collision_d   = collide_c;
        rd_vld_d      = rd_c;
        rd_is_reg_d   = reg_sel_c;
        rd_reg_data_d = (rd_c & reg_sel_c) ? reg_rdata_c : '0;
    end

    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            state_q       <= DB_IDLE;
            msg_valid_q   <= 1'b0;
            msg_len_q     <= '0;
            msg_shadow_q  <= '0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            rsp_full_q    <= 1'b0;
            rsp_len_q     <= '0;
            rsp_ready_q   <= 1'b1;
            irq_q         <= 1'b0;
            collision_q   <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_is_reg_q   <= 1'b0;
            rd_reg_data_q <= '0;
        end else begin
            state_q       <= state_d;
            msg_valid_q   <= msg_valid_d;
            msg_len_q     <= msg_len_d;
            msg_shadow_q  <= msg_shadow_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
            rsp_full_q    <= rsp_full_d;
            rsp_len_q     <= rsp_len_d;
            rsp_ready_q   <= rsp_ready_d;
            irq_q         <= irq_d;
            collision_q   <= collision_d;
            rd_vld_q      <= rd_vld_d;
            rd_is_reg_q   <= rd_is_reg_d;
            rd_reg_data_q <= rd_reg_data_d;
        end
    end

`ifdef BUS_DPRAM_MBOX_TIMEOUT_EN
    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign o_PortB_Msg_Valid = msg_valid_q;
    assign o_PortB_Msg_Len   = msg_len_q;
    assign o_PortB_Rsp_Ready = rsp_ready_q;
    assign o_PortB_Collision = collision_q;
    assign o_Bus_Irq         = irq_q;

    // First read stage: RAM and register paths merge here with equal latency
    logic [DW-1:0] s0_data_c;
    assign s0_data_c = rd_vld_q ? (rd_is_reg_q ? rd_reg_data_q : ram_dout_a) : '0;

    generate
        if (RD_PIPE == 0) begin : g_no_pipe
            assign o_Bus_Rd_Data = s0_data_c;
            assign o_Bus_Rd_DV   = rd_vld_q;
        end else begin : g_pipe
            logic [DW-1:0]      pipe_data_q [RD_PIPE];
            logic [RD_PIPE-1:0] pipe_vld_q;

            always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
                if (!i_Bus_Rst_L) begin
                    pipe_vld_q <= '0;
                    for (int i = 0; i < int'(RD_PIPE); i++) begin
                        pipe_data_q[i] <= '0;
                    end
                end else begin
                    pipe_vld_q[0]  <= rd_vld_q;
                    pipe_data_q[0] <= s0_data_c;
                    for (int i = 1; i < int'(RD_PIPE); i++) begin
                        pipe_vld_q[i]  <= pipe_vld_q[i-1];
                        pipe_data_q[i] <= pipe_data_q[i-1];
                    end
                end
            end

            assign o_Bus_Rd_Data = pipe_data_q[RD_PIPE-1];
            assign o_Bus_Rd_DV   = pipe_vld_q[RD_PIPE-1];
        end
    endgenerate

endmodule

// File: doc/bus_dpram_mailbox.md
Name: bus_dpram_mailbox

Overview:
Parametrised successor to the team's bus-attached dual-port RAM. Port A is the 16-bit register bus and addresses a RAM window plus a small control-register window. Port B is a general-purpose word port. A doorbell/response mailbox with an interrupt lets bus software and port-B logic hand buffers back and forth without polling RAM contents.

Parameters:
DEPTH, 256, RAM words (16-bit); power of 2, 16..4096.
RD_PIPE, 0, extra output register stages on bus read data, 0..2.
TIMEOUT_CYCLES, 1024, doorbell ack timeout in clocks; used only with the optional feature.

Ports:
i_Bus_Clk  in  1  single clock for everything.
i_Bus_Rst_L  in  1  asynchronous, active-low reset.
i_Bus_CS  in  1  bus access strobe, one cycle per access.
i_Bus_Wr_Rd_n  in  1  1 = write, 0 = read.
i_Bus_Addr8  in  16  byte address.
i_Bus_Wr_Data  in  16  bus write data.
o_Bus_Rd_Data  out  16  bus read data, registered.
o_Bus_Rd_DV  out  1  read-data-valid pulse.
o_Bus_Irq  out  1  level interrupt: response pending.
i_PortB_Addr16  in  $clog2(DEPTH)  port B word address.
i_PortB_Data  in  16  port B write data.
i_PortB_WE  in  1  port B write enable.
o_PortB_Data  out  16  port B read data, 1-cycle latency.
o_PortB_Collision  out  1  pulse: port B write dropped because of a collision.
o_PortB_Msg_Valid  out  1  doorbell pending toward port B.
o_PortB_Msg_Len  out  16  doorbell payload (word count).
i_PortB_Msg_Ack  in  1  port B accepts the doorbell.
i_PortB_Rsp_Valid  in  1  port B posts a response.
i_PortB_Rsp_Len  in  16  response payload.
o_PortB_Rsp_Ready  out  1  response slot empty.

Behaviour:
- Address decoding: AW = $clog2(DEPTH).
  - i_Bus_Addr8[AW+1] = 0 selects RAM at word i_Bus_Addr8[AW:1].
  - i_Bus_Addr8[AW+1] = 1 selects registers, index i_Bus_Addr8[3:1].
  - Bit 0 and bits above AW+1 are ignored.
- Registers:
  - 0x0 STATUS: b0 MSG_PEND, b1 RSP_FULL, b2 OVERRUN (sticky), b3 TIMEOUT (sticky). Writing 1 to b2/b3 clears them; other writes are ignored.
  - 0x2 MSG_LEN: a write launches a doorbell; a read returns the last written value.
  - 0x4 RSP_LEN: read only. A read returns the latched response and clears RSP_FULL.
  - 0x6 INFO: read returns DEPTH.
  - All other indexes read 0; writes to them are ignored.
- Read latency: a read with CS in cycle N gives o_Bus_Rd_DV = 1 and valid data in cycle N+1+RD_PIPE. RAM and register reads have identical latency. Back-to-back reads are fully pipelined.
- Doorbell FSM, states IDLE and PEND:
  - IDLE: a bus write to MSG_LEN latches o_PortB_Msg_Len, sets o_PortB_Msg_Valid, and moves to PEND.
  - PEND: i_PortB_Msg_Ack moves to IDLE next cycle.
  - A write to MSG_LEN while in PEND is dropped and sets OVERRUN.
  - Ack in IDLE is ignored.
- Response slot:
  - i_PortB_Rsp_Valid with o_PortB_Rsp_Ready = 1 latches the length, sets RSP_FULL, raises o_Bus_Irq, and drops Ready.
  - Valid while Ready = 0 is ignored; port B must hold Valid until Ready.
  - A bus read of RSP_LEN in the same cycle as a Rsp_Valid: the read clears the old response first; the new response is then accepted next cycle.
- RAM:
  - Port A writes when CS & Wr_Rd_n & RAM window.
  - Port A and port B writing the same word in the same cycle: port A wins, the port B write is suppressed, and o_PortB_Collision pulses for 1 cycle.
  - A same-cycle read on one port and write on the other returns the old data.
  - RAM contents are not reset.
- Reset values (async assert, sync deassert by the upstream synchroniser):
  - o_Bus_Rd_Data = 0, o_Bus_Rd_DV = 0, o_Bus_Irq = 0.
  - o_PortB_Msg_Valid = 0, o_PortB_Msg_Len = 0, o_PortB_Rsp_Ready = 1, o_PortB_Collision = 0.
  - FSM in IDLE, all status bits 0, read pipeline flushed (no DV after reset).
  - Reset mid-doorbell drops the doorbell with no ack required.

Optional Feature:
- Macro: BUS_DPRAM_MBOX_TIMEOUT_EN.
- Defined:
  - A counter runs while in PEND.
  - After TIMEOUT_CYCLES clocks with no ack: return to IDLE, deassert Msg_Valid, set TIMEOUT, pulse o_Bus_Irq for one cycle (OR-ed with RSP_FULL).
  - An ack arriving in the timeout cycle wins: no TIMEOUT is set.
- Undefined: no counter; PEND waits forever; STATUS b3 reads 0.

Decomposition:
- Package bus_dpram_pkg:
  - register index constants (STATUS/MSG_LEN/RSP_LEN/INFO);
  - STATUS bit positions;
  - doorbell state enum.
- Sub-module: reuse the existing Dual_Port_RAM_Single_Clock (WIDTH=16, DEPTH). Collision suppression is done outside it by gating port B WE.
- The mailbox FSM plus registers stay in the top level; no further split.

Test Plan:
- DEPTH=256, RD_PIPE=0: write 0xBEEF at Addr8 0x0010, read it back -> DV and 0xBEEF exactly 1 cycle after the read CS. Port B reads Addr16 8 -> 0xBEEF.
- RD_PIPE=2: reads on 4 consecutive cycles -> 4 consecutive DV pulses starting at N+3, data in address order.
- Write MSG_LEN (Addr8 0x0202) = 0x0040 -> Msg_Valid=1, Len=0x40. A second write of 0x0041 -> Len stays 0x40 and STATUS reads 0x0005. Ack -> Msg_Valid=0, STATUS b0=0.
- Rsp_Valid with Len=0x0033 -> Irq=1, Ready=0. Read 0x0204 -> 0x0033; Irq=0 and Ready=1 the next cycle.
- Same-cycle port A write 0x1111 and port B write 0x2222 to word 5 -> word 5 = 0x1111, Collision pulses once.
- With BUS_DPRAM_MBOX_TIMEOUT_EN and TIMEOUT_CYCLES=16: doorbell with no ack -> Msg_Valid drops after 16 clocks, STATUS b3=1, one-cycle Irq pulse.
